// File: rtl/mem_resp_packer_pkg.sv
// Shared types for the response packer: pack FSM states and the FIFO entry layout.
package mem_resp_packer_pkg;

   typedef enum logic {
      LOW_P  = 1'b0,
      HIGH_P = 1'b1
   } pack_state_e;

   localparam int ENTRY_W = 9;

   typedef struct packed {
      logic       partial;
      logic [7:0] data;
   } entry_t;

   function automatic entry_t make_entry(input logic partial, input logic [3:0] hi, input logic [3:0] lo);
      entry_t e;
      e.partial = partial;
      e.data    = {hi, lo};
      return e;
   endfunction

endpackage

// File: rtl/mem_resp_packer_if.sv
// Nibble input stream and byte valid/ready output of the response packer.
interface mem_resp_packer_if;
   logic       in_valid;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_partial;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_partial
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_partial
   );
endinterface

// File: rtl/mem_resp_packer_resp_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is ignored unless a pop frees the slot.
module resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_en, rd_en;

   assign full  = (count_q == FULL_COUNT);
   assign empty = (count_q == '0);
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en)
         wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en)
         rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= din;
   end

   assign dout  = empty ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/saturating_counter.sv
// Up-counter that stops at its all-ones value; cleared only by reset.
module saturating_counter #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);
   logic [WIDTH-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (inc && (value_q != '1))
         value_d = value_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         value_q <= '0;
      else
         value_q <= value_d;
   end

   assign value = value_q;
endmodule

// File: rtl/mem_resp_packer.sv
// Packs the controller's nibble stream into bytes (low nibble first), flushing a lone
// nibble after TIMEOUT idle cycles, and queues the bytes behind a valid/ready port.
module mem_resp_packer
   import mem_resp_packer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   mem_resp_packer_if.slave       bus,
   output logic                   overflow,
   output logic [7:0]             drop_count,
   output logic [$clog2(DEPTH):0] count,
   output logic [3:0]             coverage
);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   pack_state_e   state_q, state_d;
   logic [3:0]    lo_q, lo_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    drop_count_q, drop_count_d;
   logic [3:0]    cov_prev_q, cov_prev_d;
   logic [3:0]    cov_sig;

   logic          push_req;
   entry_t        push_entry;
   entry_t        head;
   logic          fifo_full, fifo_empty, pop, drop;

   // A high nibble always wins over a timeout landing in the same cycle.
   always_comb begin
      state_d    = state_q;
      lo_d       = lo_q;
      timer_d    = timer_q;
      push_req   = 1'b0;
      push_entry = '0;
      if (state_q == LOW_P) begin
         if (bus.in_valid) begin
            lo_d    = bus.in_data;
            timer_d = '0;
            state_d = HIGH_P;
         end
      end else begin
         if (bus.in_valid) begin
            push_req   = 1'b1;
            push_entry = make_entry(1'b0, bus.in_data, lo_q);
            state_d    = LOW_P;
         end else if (timer_q == TIMER_LAST) begin
            push_req   = 1'b1;
            push_entry = make_entry(1'b1, 4'h0, lo_q);
            state_d    = LOW_P;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
   end

   assign pop  = bus.out_valid & bus.out_ready;
   assign drop = push_req & fifo_full & ~pop;

   always_comb begin
      overflow_d   = overflow_q | drop;
      drop_count_d = drop_count_q;
      if (drop && (drop_count_q != 8'hFF))
         drop_count_d = drop_count_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= LOW_P;
         lo_q         <= '0;
         timer_q      <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         lo_q         <= lo_d;
         timer_q      <= timer_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   resp_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign bus.out_valid   = ~fifo_empty;
   assign bus.out_data    = head.data;
   assign bus.out_partial = head.partial;
   assign overflow        = overflow_q;
   assign drop_count      = drop_count_q;

   // Previous-value registers start at each signal's own reset value, so reset itself is no toggle.
   assign cov_sig    = {state_q == HIGH_P, fifo_full, fifo_empty, bus.in_valid};
   assign cov_prev_d = cov_sig;

   always_ff @(posedge clock) begin
      if (reset)
         cov_prev_q <= 4'b0010;
      else
         cov_prev_q <= cov_prev_d;
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cov
         saturating_counter #(
            .WIDTH (1)
         ) u_cov (
            .clock (clock),
            .reset (reset),
            .inc   (cov_sig[gi] ^ cov_prev_q[gi]),
            .value (coverage[gi])
         );
      end
   endgenerate
endmodule

// File: tb/tb_mem_resp_packer.sv
// Scoreboard bench for mem_resp_packer: directed scenarios plus randomized nibble traffic.
module tb_mem_resp_packer;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic                   clock = 1'b0;
   logic                   reset = 1'b1;
   logic                   overflow;
   logic [7:0]             drop_count;
   logic [$clog2(DEPTH):0] count;
   logic [3:0]             coverage;

   always #5 clock = ~clock;

   mem_resp_packer_if bus_if ();

   mem_resp_packer #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus_if),
      .overflow   (overflow),
      .drop_count (drop_count),
      .count      (count),
      .coverage   (coverage)
   );

   typedef struct packed {
      logic       partial;
      logic [7:0] data;
   } exp_t;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];

   // Reference model: nibble pairing by cycle numbers, FIFO as an occupancy count.
   int         cyc = 0;
   bit         lo_pending = 0;
   logic [3:0] lo_val = '0;
   int         lo_cycle = 0;
   int         m_occ = 0, cur_occ = 0;
   bit         m_ovf = 0, cur_ovf = 0;
   int         m_drop = 0, cur_drop = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step(input bit v, input logic [3:0] d, input bit rdy);
      exp_t e;
      bit   have;
      bit   pop;
      bus_if.in_valid  = v;
      bus_if.in_data   = d;
      bus_if.out_ready = rdy;
      cur_occ  = m_occ;
      cur_ovf  = m_ovf;
      cur_drop = m_drop;
      have = 0;
      e    = '0;
      if (v) begin
         if (lo_pending) begin
            e = {1'b0, d, lo_val};
            have = 1;
            lo_pending = 0;
         end else begin
            lo_pending = 1;
            lo_val = d;
            lo_cycle = cyc;
         end
      end else if (lo_pending && (cyc - lo_cycle == TIMEOUT)) begin
         e = {1'b1, 4'h0, lo_val};
         have = 1;
         lo_pending = 0;
      end
      pop = rdy && (m_occ > 0);
      if (pop)
         m_occ--;
      if (have) begin
         if (m_occ < DEPTH) begin
            m_occ++;
            sb_q.push_back(e);
         end else begin
            m_ovf = 1;
            if (m_drop < 255)
               m_drop++;
         end
      end
      cyc++;
      @(posedge clock);
      #1;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = '0;
      bus_if.out_ready = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      lo_pending = 0;
      m_occ = 0;  cur_occ = 0;
      m_ovf = 0;  cur_ovf = 0;
      m_drop = 0; cur_drop = 0;
      sb_q.delete();
      reset = 1'b0;
   endtask

   // Monitor: per-cycle status against the model, byte handshakes against the scoreboard.
   always @(negedge clock) begin
      if (!reset) begin
         check("out_valid", bus_if.out_valid, (cur_occ > 0));
         check("count", count, cur_occ);
         check("overflow", overflow, cur_ovf);
         check("drop_count", drop_count, cur_drop);
         if (!bus_if.out_valid)
            check("idle_head", {bus_if.out_partial, bus_if.out_data}, 0);
         if (bus_if.out_valid && bus_if.out_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_pop", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               $display("txn byte=%02h partial=%0d expected=%02h/%0d",
                        bus_if.out_data, bus_if.out_partial, e.data, e.partial);
               check("sb_byte", {bus_if.out_partial, bus_if.out_data}, e);
            end
         end
      end
   end

   initial begin
      reset_dut();
      check("rst_out_valid", bus_if.out_valid, 0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop", drop_count, 0);
      check("rst_coverage", coverage, 0);
      check("rst_head", {bus_if.out_partial, bus_if.out_data}, 0);

      // Pair 0x3 then 0xA.
      step(1, 4'h3, 1);
      check("s1_not_yet", bus_if.out_valid, 0);
      step(1, 4'hA, 1);
      check("s1_valid", bus_if.out_valid, 1);
      check("s1_data", bus_if.out_data, 8'hA3);
      check("s1_partial", bus_if.out_partial, 0);
      step(0, 4'h0, 1);
      step(0, 4'h0, 1);
      check("s1_cov_high", coverage[3], 1);
      check("s1_cov_inv", coverage[0], 1);
      check("s1_cov_empty", coverage[1], 1);

      // Lone nibble flushed on timeout, then high nibble exactly at the timeout cycle.
      step(1, 4'h5, 1);
      for (int i = 0; i < TIMEOUT - 1; i++)
         step(0, 4'h0, 1);
      check("s2_no_early", bus_if.out_valid, 0);
      step(0, 4'h0, 1);
      check("s2_valid", bus_if.out_valid, 1);
      check("s2_data", bus_if.out_data, 8'h05);
      check("s2_partial", bus_if.out_partial, 1);
      step(0, 4'h0, 1);
      step(1, 4'h9, 1);
      for (int i = 0; i < TIMEOUT - 1; i++)
         step(0, 4'h0, 1);
      step(1, 4'h4, 1);
      check("s2b_valid", bus_if.out_valid, 1);
      check("s2b_data", bus_if.out_data, 8'h49);
      check("s2b_partial", bus_if.out_partial, 0);
      for (int i = 0; i < TIMEOUT + 2; i++)
         step(0, 4'h0, 1);
      check("s2b_no_flush", count, 0);

      // Five bytes into a 4-deep FIFO with no consumer.
      for (int k = 1; k <= 5; k++) begin
         step(1, 4'h0, 0);
         step(1, 4'(k), 0);
      end
      check("s3_count", count, 4);
      check("s3_overflow", overflow, 1);
      check("s3_drop", drop_count, 1);
      for (int i = 0; i < 6; i++)
         step(0, 4'h0, 1);

      // Full FIFO: push and pop in the same cycle.
      for (int k = 1; k <= 4; k++) begin
         step(1, 4'(k + 4), 0);
         step(1, 4'(k), 0);
      end
      check("s4_full", count, 4);
      step(1, 4'hC, 0);
      step(1, 4'hD, 1);
      check("s4_count", count, 4);
      check("s4_drop", drop_count, 1);
      check("s4_head", bus_if.out_data, 8'h26);
      for (int i = 0; i < 6; i++)
         step(0, 4'h0, 1);

      // Reset with two bytes queued and a nibble held.
      step(1, 4'h1, 0);
      step(1, 4'h1, 0);
      step(1, 4'h2, 0);
      step(1, 4'h2, 0);
      step(1, 4'h7, 0);
      check("s5_pre_count", count, 2);
      reset_dut();
      check("s5_out_valid", bus_if.out_valid, 0);
      check("s5_count", count, 0);
      check("s5_overflow", overflow, 0);
      step(1, 4'h1, 1);
      step(1, 4'h2, 1);
      check("s5_data", bus_if.out_data, 8'h21);
      step(0, 4'h0, 1);

      // Drop counter saturation.
      reset_dut();
      for (int k = 0; k < DEPTH + 257; k++) begin
         step(1, 4'($urandom_range(0, 15)), 0);
         step(1, 4'($urandom_range(0, 15)), 0);
      end
      check("s6_drop_sat", drop_count, 8'hFF);
      check("s6_overflow", overflow, 1);
      check("s6_count", count, DEPTH);
      for (int i = 0; i < DEPTH + 2; i++)
         step(0, 4'h0, 1);

      // Randomized traffic with idle gaps long enough to provoke flushes.
      reset_dut();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            int gap;
            gap = $urandom_range(5, 12);
            for (int g = 0; g < gap; g++)
               step(0, 4'h0, $urandom_range(0, 99) < 40);
         end
         step($urandom_range(0, 99) < 45, 4'($urandom_range(0, 15)), $urandom_range(0, 99) < 40);
      end
      for (int i = 0; i < TIMEOUT + DEPTH + 4; i++)
         step(0, 4'h0, 1);
      check("final_sb_empty", sb_q.size(), 0);
      check("final_count", count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
